orb_result_packer: RTL and testbench

Downstream stage of the ORB AXI-Stream core. Consumes its 32-bit result beats (pixel byte in [31:24], blue nibble, match coordinates), packs four pixel bytes per output word for the S2MM DMA, and buffers them in a small FIFO. It also demultiplexes the alternating match-coordinate fields into a stable keypoint-pair register set for the PS interrupt path.

---
 rtl/orb_pkg.sv | 19 +
 rtl/orb_sync_fifo.sv | 36 +++
 rtl/orb_result_packer.sv | 115 +++++++++++
 tb/tb_orb_result_packer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/orb_pkg.sv
// orb_pkg: shared field layout, lane count and keep encoding for the ORB result packer
package orb_pkg;
    localparam int PIX_MSB = 31;
    localparam int PIX_LSB = 24;
    localparam int CA_LSB  = 10;
    localparam int CB_LSB  = 0;
    localparam int COORD_W = 10;
    localparam int LANES   = 4;

    typedef struct packed {
        logic       last;
        logic [3:0] keep;
        logic [31:0] data;
    } beat_t;

    function automatic logic [3:0] keep_of(input logic [2:0] lanes);
        return 4'((5'd1 << lanes) - 5'd1);
    endfunction
endpackage

// File: rtl/orb_sync_fifo.sv
// orb_sync_fifo: first-word-fall-through FIFO with occupancy output; head reads as zero when empty
module orb_sync_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;

    assign empty = level == '0;
    assign dout  = empty ? '0 : mem[rp];

    always_ff @(posedge clk) if (push) mem[wp] <= din;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/orb_result_packer.sv
// orb_result_packer: packs four pixel bytes per output word into a FWFT FIFO and
// demultiplexes alternating coordinate fields into a held keypoint pair
module orb_result_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int COORD_W    = 10
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_areset,
    input  logic [31:0]                   s_axis_tdata,
    input  logic [3:0]                    s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [31:0]                   m_axis_tdata,
    output logic [3:0]                    m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [COORD_W-1:0]            match_x1,
    output logic [COORD_W-1:0]            match_y1,
    output logic [COORD_W-1:0]            match_x2,
    output logic [COORD_W-1:0]            match_y2,
    output logic                          match_valid,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    import orb_pkg::*;

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                  acc, kept, push, pop, empty, phase, unused_blue;
    logic [1:0]            lane;
    logic [31:0]           word, word_nxt;
    logic [COORD_W-1:0]    cx1, cy1, ca, cb;
    logic [4*COORD_W-1:0]  cand;
    beat_t                 in_beat, head;

    assign acc         = s_axis_tvalid && s_axis_tready;
    assign kept        = s_axis_tkeep == 4'hf;
    assign ca          = s_axis_tdata[CA_LSB +: COORD_W];
    assign cb          = s_axis_tdata[CB_LSB +: COORD_W];
    assign cand        = {cx1, cy1, ca, cb};
    assign unused_blue = ^s_axis_tdata[PIX_LSB-1:CA_LSB+COORD_W];
    // Readiness depends only on the registered level, never on m_axis_tready
    assign s_axis_tready = !s_axis_areset && (fifo_level < LW'(FIFO_DEPTH));

    always_comb begin
        word_nxt = word;
        word_nxt[{lane, 3'b000} +: 8] = s_axis_tdata[PIX_MSB:PIX_LSB];
    end

    // A kept beat closes a word on the 4th lane or on tlast; a discarded tlast only flushes pending pixels
    assign push = acc && (kept ? (lane == 2'(LANES - 1) || s_axis_tlast) : (s_axis_tlast && lane != 2'd0));
    assign in_beat = '{
        last: s_axis_tlast,
        keep: keep_of(kept ? 3'(lane) + 3'd1 : 3'(lane)),
        data: kept ? word_nxt : word
    };

    assign pop = !empty && m_axis_tready;

    orb_sync_fifo #(.W($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (s_axis_aclk),
        .rst   (s_axis_areset),
        .push  (push),
        .din   (in_beat),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .level (fifo_level)
    );

    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = head.data;
    assign m_axis_tkeep  = head.keep;
    assign m_axis_tlast  = head.last;

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            lane        <= '0;
            word        <= '0;
            phase       <= 1'b0;
            cx1         <= '0;
            cy1         <= '0;
            match_x1    <= '0;
            match_y1    <= '0;
            match_x2    <= '0;
            match_y2    <= '0;
            match_valid <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            match_valid <= 1'b0;
            frame_done  <= pop && head.last;
            if (acc) begin
                if (push) begin
                    lane <= '0;
                    word <= '0;
                end else if (kept) begin
                    lane <= lane + 2'd1;
                    word <= word_nxt;
                end
                phase <= !s_axis_tlast && (phase ^ kept);
                if (kept && !phase) begin
                    cx1 <= ca;
                    cy1 <= cb;
                end
                // Only a fresh, non-zero pair is published
                if (kept && phase && cand != '0 && cand != {match_x1, match_y1, match_x2, match_y2}) begin
                    {match_x1, match_y1, match_x2, match_y2} <= cand;
                    match_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_orb_result_packer.sv
// tb_orb_result_packer: scenario tasks checked against a queue-based packing and pairing model
module tb_orb_result_packer;
    localparam int DEPTH = 16;
    localparam int CW    = 10;

    logic          s_axis_aclk = 1'b0;
    logic          s_axis_areset = 1'b1;
    logic [31:0]   s_axis_tdata = '0;
    logic [3:0]    s_axis_tkeep = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [31:0]   m_axis_tdata;
    logic [3:0]    m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [CW-1:0] match_x1, match_y1, match_x2, match_y2;
    logic          match_valid, frame_done;
    logic [$clog2(DEPTH):0] fifo_level;

    orb_result_packer #(.FIFO_DEPTH(DEPTH), .COORD_W(CW)) dut (
        .s_axis_aclk   (s_axis_aclk),
        .s_axis_areset (s_axis_areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .match_x1      (match_x1),
        .match_y1      (match_y1),
        .match_x2      (match_x2),
        .match_y2      (match_y2),
        .match_valid   (match_valid),
        .frame_done    (frame_done),
        .fifo_level    (fifo_level)
    );

    always #5 s_axis_aclk = ~s_axis_aclk;

    int checks = 0;
    int failures = 0;

    logic [36:0] got_q[$], exp_q[$], seen_q[$];
    logic [7:0]  pend[$];
    int          k_idx = 0;
    logic [19:0] first_half = '0;
    logic [39:0] held = '0;
    int          exp_mv = 0, mv_cnt = 0, fd_cnt = 0, fd_bad = 0;
    logic        fd_pend = 1'b0;
    int          rdy_mode = 1;

    // 0: hold off, 1: always ready, 2: random
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge s_axis_aclk);
            #1;
            m_axis_tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        end
    end

    // Records pops (taken at the next edge) and tracks frame_done / match_valid pulses
    always @(negedge s_axis_aclk) begin
        if (s_axis_areset) begin
            fd_pend = 1'b0;
        end else begin
            if (frame_done !== fd_pend) fd_bad++;
            if (frame_done === 1'b1) fd_cnt++;
            if (match_valid === 1'b1) mv_cnt++;
            fd_pend = m_axis_tvalid && m_axis_tready && m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [7:0] p, input logic [9:0] a, input logic [9:0] b);
        return {p, 4'($urandom), a, b};
    endfunction

    task automatic model_accept(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic [31:0] w;
        logic [39:0] c;
        if (k == 4'hf) begin
            pend.push_back(d[31:24]);
            if (k_idx % 2 == 0) first_half = d[19:0];
            else begin
                c = {first_half, d[19:0]};
                if (c != 40'd0 && c != held) begin
                    held = c;
                    exp_mv++;
                end
            end
            k_idx++;
        end
        if (pend.size() == 4 || (l && pend.size() > 0)) begin
            w = '0;
            foreach (pend[i]) w[i*8 +: 8] = pend[i];
            exp_q.push_back({l, 4'((1 << pend.size()) - 1), w});
            pend.delete();
        end
        if (l) k_idx = 0;
    endtask

    task automatic model_reset();
        pend.delete();
        exp_q.delete();
        got_q.delete();
        k_idx = 0;
        held = '0;
    endtask

    task automatic align();
        @(posedge s_axis_aclk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t = 0;
        s_axis_tdata = d;
        s_axis_tkeep = k;
        s_axis_tlast = l;
        s_axis_tvalid = 1'b1;
        @(negedge s_axis_aclk);
        while (!s_axis_tready && t < 2000) begin
            @(negedge s_axis_aclk);
            t++;
        end
        if (!s_axis_tready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: s_axis_tready=%b required 1", s_axis_tready);
        end else model_accept(d, k, l);
        @(posedge s_axis_aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input string nm, output int nlast);
        int t = 0;
        rdy_mode = 1;
        nlast = 0;
        while ((got_q.size() < exp_q.size() || m_axis_tvalid) && t < 3000) begin
            @(negedge s_axis_aclk);
            t++;
        end
        repeat (2) @(negedge s_axis_aclk);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_count: got %0d words required %0d", nm, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (exp_q[i][36]) nlast++;
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL %s_word%0d: got %h required %h", nm, i, got_q[i], exp_q[i]);
                end
            end
        end
        seen_q = got_q;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge s_axis_aclk);
        @(negedge s_axis_aclk);
        checks++;
        if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %b required 0", s_axis_tready); end
        checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== 38'd0) begin
            failures++; $display("FAIL reset_m_axis: got %b %h %h %b required zeros", m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end
        checks++;
        if (fifo_level !== '0) begin failures++; $display("FAIL reset_level: got %0d required 0", fifo_level); end
        checks++;
        if ({match_x1, match_y1, match_x2, match_y2, match_valid, frame_done} !== 42'd0) begin
            failures++; $display("FAIL reset_match: got %0d %0d %0d %0d %b %b required zeros", match_x1, match_y1, match_x2, match_y2, match_valid, frame_done);
        end
        align();
        s_axis_areset = 1'b0;
        @(negedge s_axis_aclk);
        checks++;
        if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL post_reset_tready: got %b required 1", s_axis_tready); end
    endtask

    task automatic test_full_words();
        int fd0 = fd_cnt, nl;
        align();
        for (int i = 1; i <= 8; i++) send(mk(8'(i), 10'($urandom), 10'($urandom)), 4'hf, i == 8);
        drain("full", nl);
        checks++;
        if (seen_q.size() != 2 || seen_q[0] !== {1'b0, 4'hf, 32'h04030201} || seen_q[1] !== {1'b1, 4'hf, 32'h08070605}) begin
            failures++; $display("FAIL full_words_const: got %0d words first %h required 2 words 0f04030201, 1f08070605", seen_q.size(), seen_q.size() > 0 ? seen_q[0] : 37'd0);
        end
        checks++;
        if (fd_cnt - fd0 !== 1 || fd_bad !== 0) begin failures++; $display("FAIL full_frame_done: got pulses %0d misplaced %0d required 1 and 0", fd_cnt - fd0, fd_bad); end
    endtask

    task automatic test_partial();
        int fd0 = fd_cnt, nl;
        align();
        for (int i = 0; i < 6; i++) send(mk(8'(8'h10 + i), 10'($urandom), 10'($urandom)), 4'hf, i == 5);
        drain("partial", nl);
        checks++;
        if (seen_q.size() != 2 || seen_q[0] !== {1'b0, 4'hf, 32'h13121110} || seen_q[1] !== {1'b1, 4'h3, 32'h00001514}) begin
            failures++; $display("FAIL partial_const: got %0d words last %h required 2 words ending 1300001514", seen_q.size(), seen_q.size() > 0 ? seen_q[seen_q.size()-1] : 37'd0);
        end
        checks++;
        if (fd_cnt - fd0 !== nl) begin failures++; $display("FAIL partial_frame_done: got %0d required %0d", fd_cnt - fd0, nl); end
    endtask

    task automatic test_coords();
        int mv0 = mv_cnt, nl;
        logic [9:0] ca [6] = '{10'd100, 10'd200, 10'd100, 10'd200, 10'd0, 10'd0};
        logic [9:0] cb [6] = '{10'd50, 10'd75, 10'd50, 10'd75, 10'd0, 10'd0};
        align();
        for (int i = 0; i < 6; i++) send(mk(8'($urandom), ca[i], cb[i]), 4'hf, i == 5);
        drain("coords", nl);
        checks++;
        if ({match_x1, match_y1, match_x2, match_y2} !== {10'd100, 10'd50, 10'd200, 10'd75}) begin
            failures++; $display("FAIL coords_pair: got %0d %0d %0d %0d required 100 50 200 75", match_x1, match_y1, match_x2, match_y2);
        end
        checks++;
        if (mv_cnt - mv0 !== 1 || mv_cnt !== exp_mv) begin failures++; $display("FAIL coords_pulses: got %0d total %0d required 1 total %0d", mv_cnt - mv0, mv_cnt, exp_mv); end
    endtask

    task automatic test_discard();
        int fd0 = fd_cnt, nl;
        align();
        send(mk(8'hc1, 10'd1, 10'd2), 4'hf, 1'b0);
        send(mk(8'hee, 10'd9, 10'd9), 4'h3, 1'b0);
        send(mk(8'hc2, 10'd3, 10'd4), 4'hf, 1'b0);
        send(mk(8'hc3, 10'd0, 10'd0), 4'hf, 1'b0);
        send(mk(8'hc4, 10'd0, 10'd0), 4'hf, 1'b1);
        checks++;
        @(negedge s_axis_aclk);
        if ({match_x1, match_y1, match_x2, match_y2} !== {10'd1, 10'd2, 10'd3, 10'd4}) begin
            failures++; $display("FAIL discard_pair: got %0d %0d %0d %0d required 1 2 3 4", match_x1, match_y1, match_x2, match_y2);
        end
        align();
        send(mk(8'hd1, 10'd5, 10'd6), 4'hf, 1'b0);
        send(mk(8'hd2, 10'd7, 10'd8), 4'hf, 1'b0);
        send(mk(8'hef, 10'd9, 10'd9), 4'h7, 1'b1);
        send(mk(8'hf0, 10'd9, 10'd9), 4'h1, 1'b1);
        drain("discard", nl);
        checks++;
        if (seen_q.size() != 2 || seen_q[0] !== {1'b1, 4'hf, 32'hc4c3c2c1} || seen_q[1] !== {1'b1, 4'h3, 32'h0000d2d1}) begin
            failures++; $display("FAIL discard_const: got %0d words first %h required 2 words 1fc4c3c2c1, 130000d2d1", seen_q.size(), seen_q.size() > 0 ? seen_q[0] : 37'd0);
        end
        checks++;
        if (fd_cnt - fd0 !== 2 || fd_bad !== 0) begin failures++; $display("FAIL discard_frame_done: got %0d misplaced %0d required 2 and 0", fd_cnt - fd0, fd_bad); end
        checks++;
        if ({match_x1, match_y1, match_x2, match_y2} !== held) begin
            failures++; $display("FAIL discard_held: got %h required %h", {match_x1, match_y1, match_x2, match_y2}, held);
        end
    endtask

    task automatic test_backpressure();
        int nl;
        align();
        rdy_mode = 0;
        repeat (2) align();
        for (int i = 0; i < DEPTH * 4; i++) send(mk(8'($urandom), 10'($urandom), 10'($urandom)), 4'hf, 1'b0);
        @(negedge s_axis_aclk);
        checks++;
        if (fifo_level !== ($clog2(DEPTH)+1)'(DEPTH)) begin failures++; $display("FAIL bp_level: got %0d required %0d", fifo_level, DEPTH); end
        checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL bp_handshake: got tready=%b tvalid=%b required 0 1", s_axis_tready, m_axis_tvalid); end
        align();
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) send(mk(8'($urandom), 10'($urandom), 10'($urandom)), 4'hf, i == 3);
        drain("bp", nl);
        checks++;
        if (fd_bad !== 0) begin failures++; $display("FAIL bp_frame_done: got %0d misplaced required 0", fd_bad); end
    endtask

    task automatic test_random();
        int fd0 = fd_cnt, nl;
        logic [3:0] k;
        logic l;
        align();
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            k = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 14)) : 4'hf;
            l = (i == 299) || ($urandom_range(0, 11) == 0);
            send(mk(8'($urandom), 10'($urandom_range(0, 2)), 10'($urandom_range(0, 2))), k, l);
        end
        drain("random", nl);
        checks++;
        if (fd_cnt - fd0 !== nl || fd_bad !== 0) begin failures++; $display("FAIL random_frame_done: got %0d misplaced %0d required %0d and 0", fd_cnt - fd0, fd_bad, nl); end
        checks++;
        if (mv_cnt !== exp_mv) begin failures++; $display("FAIL random_pulses: got %0d required %0d", mv_cnt, exp_mv); end
        checks++;
        if ({match_x1, match_y1, match_x2, match_y2} !== held) begin
            failures++; $display("FAIL random_held: got %h required %h", {match_x1, match_y1, match_x2, match_y2}, held);
        end
    endtask

    task automatic test_mid_reset();
        int nl;
        align();
        rdy_mode = 0;
        for (int i = 0; i < 7; i++) send(mk(8'($urandom), 10'(i + 11), 10'(i + 12)), 4'hf, 1'b0);
        s_axis_areset = 1'b1;
        align();
        model_reset();
        @(negedge s_axis_aclk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || fifo_level !== '0 || s_axis_tready !== 1'b0) begin
            failures++; $display("FAIL midreset_outputs: got tvalid=%b level=%0d tready=%b required 0 0 0", m_axis_tvalid, fifo_level, s_axis_tready);
        end
        checks++;
        if ({match_x1, match_y1, match_x2, match_y2} !== 40'd0) begin
            failures++; $display("FAIL midreset_match: got %h required 0", {match_x1, match_y1, match_x2, match_y2});
        end
        align();
        s_axis_areset = 1'b0;
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) send(mk(8'(8'ha0 + i), 10'(21 + 2 * i), 10'(22 + 2 * i)), 4'hf, i == 3);
        drain("midreset", nl);
        checks++;
        if (seen_q.size() != 1 || seen_q[0] !== {1'b1, 4'hf, 32'ha3a2a1a0}) begin
            failures++; $display("FAIL midreset_word: got %0d words first %h required 1 word 1fa3a2a1a0", seen_q.size(), seen_q.size() > 0 ? seen_q[0] : 37'd0);
        end
        checks++;
        if ({match_x1, match_y1, match_x2, match_y2} !== {10'd25, 10'd26, 10'd27, 10'd28}) begin
            failures++; $display("FAIL midreset_pair: got %0d %0d %0d %0d required 25 26 27 28", match_x1, match_y1, match_x2, match_y2);
        end
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_partial();
        test_coords();
        test_discard();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
